matrix_wb_arbiter: RTL and testbench
====================================

// Module: matrix_wb_arbiter
// PURPOSE
//  Two-master / one-slave pipelined Wishbone arbiter in front of the 8x8 matrix framebuffer slave.
//  Shares the slave between move_master (M0) and a second requester (M1, e.g. ESP32/UART command bridge).
//  Grant is held for a master's whole CYC; round-robin between masters; optional hung-slave timeout recovery.
// PARAMETERS
//  AW              3     address width (8 framebuffer words)
//  DW              32    data width; SW = DW/8 byte selects (derived localparam)
//  OUT_W           3     outstanding-transaction counter width; max in flight = 2**OUT_W-1
//  TIMEOUT_CYCLES  1024  cycles without ACK (while outstanding>0) before forced recovery
// PORTS
//  clk                              in   1    system clock
//  reset                            in   1    synchronous, active-high reset
//  i_m0_wb_cyc/stb/we               in   1    M0 cycle / strobe / write enable
//  i_m0_wb_addr                     in   AW   M0 address
//  i_m0_wb_sel                      in   SW   M0 byte select
//  i_m0_wb_wdata                    in   DW   M0 write data
//  o_m0_wb_ack/stall                out  1    M0 ack / stall
//  o_m0_wb_rdata                    out  DW   M0 read data
//  i_m1_* / o_m1_*                  --   --   identical set for M1
//  o_s_wb_cyc/stb/we                out  1    to slave
//  o_s_wb_addr/sel/wdata            out  AW/SW/DW  to slave
//  i_s_wb_ack/stall                 in   1    from slave
//  i_s_wb_rdata                     in   DW   from slave
//  o_timeout                        out  1    sticky: a timeout recovery has occurred
// BEHAVIOUR
//  Reset: state=IDLE, last=M1 (M0 wins first tie), outstanding=0, timer=0, o_timeout=0.
//   All o_s_wb_* 0, both master stalls 1, acks 0 from first cycle after reset edge.
//  States: IDLE, OWN0, OWN1, FLUSH (FLUSH only with macro).
//   IDLE: slave cyc/stb=0; both masters stall=1.
//    Any cyc -> OWNx next edge; if both, pick the one != last (1-cycle grant latency).
//   OWNx: o_s_wb_* = Mx request (comb mux); o_s_wb_cyc = i_mx_wb_cyc.
//    Mx stall = i_s_wb_stall | (outstanding==max); Mx ack = i_s_wb_ack.
//    Other master: stall=1, ack=0.
//    Mx drops cyc: last<=x; next = OWN(other) if other cyc high this cycle, else IDLE (zero-gap handover).
//  rdata: i_s_wb_rdata broadcast to both masters; only ack qualifies it.
//  Outstanding: +1 on accepted strobe (stb & ~stall to owner), -1 on ack; both same cycle -> unchanged.
//   Cleared on owner cyc drop (abandoned transactions discarded; late slave ack ignored in IDLE).
//  Strobe at outstanding==max is stalled by the arbiter, never forwarded.
//  Reset mid-transaction: takes effect at next edge, no slave strobe issued after it; no ack completion.
// CONFIGURATION
//  MATRIX_ARB_TIMEOUT_EN defined:
//   timer counts in OWNx while outstanding>0; cleared on any ack or outstanding==0.
//   timer==TIMEOUT_CYCLES-1 -> FLUSH, o_timeout<=1 (sticky until reset).
//   FLUSH: slave cyc=0; owner stall=1; one synthetic ack (rdata=0) per cycle to owner.
//    outstanding decrements per synthetic ack; at 0 -> IDLE, last<=owner.
//  Not defined: no timer, no FLUSH state; o_timeout tied 0; a hung slave blocks the bus forever.
// STRUCTURE
//  Shared package matrix_pkg: MATRIX_WB_AW=3, MATRIX_WB_DW=32 constants; arb_state_t enum {IDLE,OWN0,OWN1,FLUSH}.
//  One sub-module: arb_txn_counter (outstanding up/down counter + full flag + timeout timer).
//  Top-level: state FSM and comb muxes.
// TESTING
//  1 M0 only: write addr 3, sel 4'b0011, data 32'h0000_0705.
//    -> slave sees stb 1 cycle after cyc rise with same fields; ack to M0 only.
//  2 M0 and M1 raise cyc same cycle after reset.
//    -> OWN0; M1 stall=1 throughout.
//    -> M0 drops cyc: next cycle OWN1, no idle gap; both again after -> M0 (round robin).
//  3 Slave stall held 3 cycles during M1 strobe.
//    -> M1 stall=1 for those 3 cycles; outstanding stays 0 until accepted, then 1.
//  4 OUT_W=3, slave never acks, M0 issues pipelined strobes.
//    -> 7 accepted; 8th held with M0 stall=1 and o_s_wb_stb=0.
//  5 Macro on, TIMEOUT_CYCLES=16, 2 strobes unacked.
//    -> 16 cycles later o_timeout=1, 2 consecutive acks to M0 with rdata=0, IDLE.
//    Macro off: stays OWN0 indefinitely, o_timeout=0.
//  6 reset asserted mid-burst with outstanding=2.
//    -> next cycle IDLE, slave cyc=0, both stalls=1, no acks to either master.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and FSM state type for the matrix framebuffer Wishbone arbiter.
package matrix_pkg;

    localparam int unsigned MATRIX_WB_AW = 3;
    localparam int unsigned MATRIX_WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        FLUSH = 2'd3
    } arb_state_t;

endpackage

// File: rtl/matrix_wb_arbiter_if.sv
// Pipelined Wishbone bundle; "master" drives requests, "slave" drives ack/stall/rdata.
interface matrix_wb_arbiter_if
    import matrix_pkg::*;
#(
    parameter int unsigned AW = MATRIX_WB_AW,
    parameter int unsigned DW = MATRIX_WB_DW
);
    localparam int unsigned SW = DW / 8;

    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          stall;
    logic [DW-1:0] rdata;

    modport master (
        output cyc, stb, we, addr, sel, wdata,
        input  ack, stall, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, sel, wdata,
        output ack, stall, rdata
    );

endinterface

// File: rtl/matrix_wb_arbiter_txn_counter.sv
// Outstanding-transaction up/down counter with full flag and hung-slave timer.
// Timer present only when MATRIX_ARB_TIMEOUT_EN is defined.
module arb_txn_counter #(
    parameter int unsigned OUT_W          = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             run,
    output logic [OUT_W-1:0] count,
    output logic             full,
    output logic             timeout_hit
);

    logic [OUT_W-1:0] count_q, count_d;
    logic             dec_ok;

    // An ack with nothing outstanding must not wrap the counter.
    assign dec_ok = dec & (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec_ok) begin
            count_d = count_q + 1'b1;
        end else if (!inc && dec_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == '1);

`ifdef MATRIX_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] timer_q, timer_d;
    logic          waiting;

    assign waiting     = run & (count_q != '0) & ~dec & ~clr;
    assign timer_d     = waiting ? timer_q + 1'b1 : '0;
    assign timeout_hit = waiting & (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_run;

    assign unused_run  = run;
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/matrix_wb_arbiter.sv
// Two-master / one-slave round-robin pipelined Wishbone arbiter for the matrix framebuffer.
// Define MATRIX_ARB_TIMEOUT_EN to enable hung-slave timeout recovery (FLUSH state).
module matrix_wb_arbiter
    import matrix_pkg::*;
#(
    parameter int unsigned AW             = MATRIX_WB_AW,
    parameter int unsigned DW             = MATRIX_WB_DW,
    parameter int unsigned OUT_W          = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    matrix_wb_arbiter_if.slave  m0_wb,
    matrix_wb_arbiter_if.slave  m1_wb,
    matrix_wb_arbiter_if.master s_wb,
    output logic                o_timeout
);

    localparam int unsigned SW = DW / 8;

    arb_state_t state_q, state_d;
    logic       last_q, last_d;

    logic             own;
    logic             own_sel;
    logic             other_cyc;
    logic             req_cyc, req_stb, req_we;
    logic [AW-1:0]    req_addr;
    logic [SW-1:0]    req_sel;
    logic [DW-1:0]    req_wdata;
    logic             owner_stall, owner_ack;
    logic [DW-1:0]    rdata;
    logic             inc, dec, clr;
    logic [OUT_W-1:0] outstanding;
    logic             full;
    logic             timeout_hit;

    assign own = (state_q == OWN0) || (state_q == OWN1);
    // In FLUSH the owner is remembered in last_q, which was loaded on entry.
    assign own_sel = (state_q == OWN1) || ((state_q == FLUSH) && last_q);

    assign req_cyc   = own_sel ? m1_wb.cyc   : m0_wb.cyc;
    assign req_stb   = own_sel ? m1_wb.stb   : m0_wb.stb;
    assign req_we    = own_sel ? m1_wb.we    : m0_wb.we;
    assign req_addr  = own_sel ? m1_wb.addr  : m0_wb.addr;
    assign req_sel   = own_sel ? m1_wb.sel   : m0_wb.sel;
    assign req_wdata = own_sel ? m1_wb.wdata : m0_wb.wdata;
    assign other_cyc = own_sel ? m0_wb.cyc   : m1_wb.cyc;

    always_comb begin
        s_wb.cyc    = 1'b0;
        s_wb.stb    = 1'b0;
        s_wb.we     = 1'b0;
        s_wb.addr   = '0;
        s_wb.sel    = '0;
        s_wb.wdata  = '0;
        owner_stall = 1'b1;
        owner_ack   = 1'b0;
        rdata       = s_wb.rdata;
        inc         = 1'b0;
        dec         = 1'b0;
        clr         = 1'b0;
        if (own) begin
            s_wb.cyc    = req_cyc;
            // A full pipeline holds the strobe back rather than overrunning the counter.
            s_wb.stb    = req_cyc & req_stb & ~full;
            s_wb.we     = req_we;
            s_wb.addr   = req_addr;
            s_wb.sel    = req_sel;
            s_wb.wdata  = req_wdata;
            owner_stall = s_wb.stall | full;
            owner_ack   = s_wb.ack;
            inc         = req_cyc & req_stb & ~owner_stall;
            dec         = s_wb.ack;
            clr         = ~req_cyc;
        end
`ifdef MATRIX_ARB_TIMEOUT_EN
        if (state_q == FLUSH) begin
            owner_ack = 1'b1;
            rdata     = '0;
            dec       = 1'b1;
        end
`endif
    end

    assign m0_wb.stall = own_sel | owner_stall;
    assign m1_wb.stall = ~own_sel | owner_stall;
    assign m0_wb.ack   = ~own_sel & owner_ack;
    assign m1_wb.ack   = own_sel & owner_ack;
    assign m0_wb.rdata = rdata;
    assign m1_wb.rdata = rdata;

`ifdef MATRIX_ARB_TIMEOUT_EN
    logic timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
`ifdef MATRIX_ARB_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_wb.cyc && (!m1_wb.cyc || last_q)) begin
                    state_d = OWN0;
                end else if (m1_wb.cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!req_cyc) begin
                    last_d  = own_sel;
                    state_d = other_cyc ? (own_sel ? OWN0 : OWN1) : IDLE;
                end
`ifdef MATRIX_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    last_d    = own_sel;
                    state_d   = FLUSH;
                    timeout_d = 1'b1;
                end
`endif
            end
`ifdef MATRIX_ARB_TIMEOUT_EN
            FLUSH: begin
                if (outstanding <= OUT_W'(1)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

`ifdef MATRIX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_timeout_hit;

    assign unused_timeout_hit = timeout_hit;
    assign o_timeout          = 1'b0;
`endif

    arb_txn_counter #(
        .OUT_W          (OUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_txn_counter (
        .clk         (clk),
        .reset       (reset),
        .inc         (inc),
        .dec         (dec),
        .clr         (clr),
        .run         (own),
        .count       (outstanding),
        .full        (full),
        .timeout_hit (timeout_hit)
    );

endmodule

// File: tb/tb_matrix_wb_arbiter.sv
// Self-checking bench for matrix_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of owner, round-robin and outstanding count.
module tb_matrix_wb_arbiter;
    import matrix_pkg::*;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned OUT_W = 3;
    localparam int unsigned TMO = 16;
    localparam int MAXO = (1 << OUT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic timeout;

    always #5 clk = ~clk;

    matrix_wb_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    matrix_wb_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();
    matrix_wb_arbiter_if #(.AW(AW), .DW(DW)) s_if ();

    logic [1:0]    m_cyc, m_stb, m_we;
    logic [AW-1:0] m_addr [2];
    logic [SW-1:0] m_sel [2];
    logic [DW-1:0] m_wdata [2];
    logic          sl_stall, sl_ack;
    logic [DW-1:0] sl_rdata;

    assign m0_if.cyc = m_cyc[0];     assign m1_if.cyc = m_cyc[1];
    assign m0_if.stb = m_stb[0];     assign m1_if.stb = m_stb[1];
    assign m0_if.we = m_we[0];       assign m1_if.we = m_we[1];
    assign m0_if.addr = m_addr[0];   assign m1_if.addr = m_addr[1];
    assign m0_if.sel = m_sel[0];     assign m1_if.sel = m_sel[1];
    assign m0_if.wdata = m_wdata[0]; assign m1_if.wdata = m_wdata[1];
    assign s_if.stall = sl_stall;
    assign s_if.ack = sl_ack;
    assign s_if.rdata = sl_rdata;

    matrix_wb_arbiter #(
        .AW             (AW),
        .DW             (DW),
        .OUT_W          (OUT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_wb     (m0_if),
        .m1_wb     (m1_if),
        .s_wb      (s_if),
        .o_timeout (timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who went last, how many strobes are in flight.
    int owner = -1;
    int last = 1;
    int outst = 0;
    bit model_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            owner = -1;
            last  = 1;
            outst = 0;
        end else if (owner < 0) begin
            if (m_cyc == 2'b11) owner = (last == 0) ? 1 : 0;
            else if (m_cyc[0]) owner = 0;
            else if (m_cyc[1]) owner = 1;
        end else if (!m_cyc[owner]) begin
            last  = owner;
            outst = 0;
            owner = m_cyc[1-owner] ? 1 - owner : -1;
        end else begin
            int acc, dn;
            acc   = (m_stb[owner] && !sl_stall && outst < MAXO) ? 1 : 0;
            dn    = (sl_ack && outst > 0) ? 1 : 0;
            outst = outst + acc - dn;
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            logic [5:0]  exp_ctl;
            logic [39:0] exp_req;
            logic        c, st, ostall;
            if (owner < 0) begin
                exp_ctl = 6'b001010;
                exp_req = '0;
            end else begin
                c      = m_cyc[owner];
                st     = m_cyc[owner] & m_stb[owner] & (outst < MAXO);
                ostall = sl_stall | (outst == MAXO);
                if (owner == 0) exp_ctl = {c, st, ostall, sl_ack, 1'b1, 1'b0};
                else            exp_ctl = {c, st, 1'b1, 1'b0, ostall, sl_ack};
                exp_req = {m_we[owner], m_addr[owner], m_sel[owner], m_wdata[owner]};
            end
            check_eq("model_ctl", {s_if.cyc, s_if.stb, m0_if.stall, m0_if.ack,
                                   m1_if.stall, m1_if.ack}, exp_ctl);
            check_eq("model_req", {s_if.we, s_if.addr, s_if.sel, s_if.wdata}, exp_req);
            check_eq("model_rdata", {m0_if.rdata, m1_if.rdata}, {sl_rdata, sl_rdata});
            check_eq("model_tmo", timeout, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m_cyc = '0;
        m_stb = '0;
        m_we = '0;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0;
            m_sel[i] = '0;
            m_wdata[i] = '0;
        end
        sl_stall = 1'b0;
        sl_ack = 1'b0;
        sl_rdata = '0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nak;
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_en = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_s_cyc_stb", {s_if.cyc, s_if.stb}, 2'b00);
        check_eq("rst_stalls", {m0_if.stall, m1_if.stall}, 2'b11);
        check_eq("rst_acks", {m0_if.ack, m1_if.ack}, 2'b00);
        check_eq("rst_out_tmo", {timeout, dut.outstanding}, 4'd0);

        // 1: M0 alone writes addr 3
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_addr[0] = 3'd3; m_sel[0] = 4'b0011; m_wdata[0] = 32'h0000_0705;
        @(negedge clk);
        check_eq("t1_latency", s_if.stb, 1'b0);
        step();
        @(negedge clk);
        check_eq("t1_fwd", {s_if.stb, s_if.we, s_if.addr, s_if.sel, s_if.wdata},
                 {1'b1, 1'b1, 3'd3, 4'b0011, 32'h0000_0705});
        check_eq("t1_m0_stall", m0_if.stall, 1'b0);
        step();
        m_stb[0] = 1'b0; sl_ack = 1'b1; sl_rdata = 32'h0000_CAFE;
        @(negedge clk);
        check_eq("t1_acks", {m0_if.ack, m1_if.ack}, 2'b10);
        check_eq("t1_rdata", m0_if.rdata, 32'h0000_CAFE);
        step();
        sl_ack = 1'b0; m_cyc[0] = 1'b0;
        step();

        // 2: simultaneous request, zero-gap handover, round robin
        do_reset();
        m_cyc = 2'b11;
        step();
        @(negedge clk);
        check_eq("t2_grant0", {s_if.cyc, m0_if.stall, m1_if.stall}, 3'b101);
        step();
        @(negedge clk);
        check_eq("t2_m1_hold", m1_if.stall, 1'b1);
        step();
        m_cyc[0] = 1'b0;
        step();
        @(negedge clk);
        check_eq("t2_handover", {s_if.cyc, m0_if.stall, m1_if.stall}, 3'b110);
        step();
        m_cyc = 2'b00;
        step();
        m_cyc = 2'b11;
        step();
        @(negedge clk);
        check_eq("t2_rr", {m0_if.stall, m1_if.stall}, 2'b01);
        step();
        m_cyc = 2'b00;
        step();

        // 3: slave stall during M1 strobe
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; sl_stall = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t3_stalled", {m1_if.stall, dut.outstanding}, {1'b1, 3'd0});
            step();
        end
        sl_stall = 1'b0;
        @(negedge clk);
        check_eq("t3_go", {m1_if.stall, dut.outstanding}, {1'b0, 3'd0});
        step();
        m_stb[1] = 1'b0;
        @(negedge clk);
        check_eq("t3_out1", dut.outstanding, 3'd1);
        sl_ack = 1'b1;
        step();
        sl_ack = 1'b0; m_cyc[1] = 1'b0;
        step();

        // 4: no acks, pipeline fills to the limit
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        step();
        for (int i = 0; i < MAXO; i++) begin
            @(negedge clk);
            check_eq("t4_accept", {s_if.stb, m0_if.stall}, 2'b10);
            step();
        end
        @(negedge clk);
        check_eq("t4_full", {s_if.stb, m0_if.stall, dut.outstanding}, {2'b01, 3'd7});
        step();
        @(negedge clk);
        check_eq("t4_hold", {s_if.stb, m0_if.stall, dut.outstanding}, {2'b01, 3'd7});
        step();
        m_cyc = 2'b00; m_stb = 2'b00;
        step();

        // 5: hung slave with 2 strobes outstanding
        do_reset();
        sl_rdata = 32'hDEAD_BEEF;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        step();
        step();
        step();
        m_stb[0] = 1'b0;
`ifdef MATRIX_ARB_TIMEOUT_EN
        model_en = 1'b0;
        n = 0;
        @(negedge clk);
        while (!timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_tmo_seen", timeout, 1'b1);
        check_eq("t5_tmo_delay", (n >= 13 && n <= 17), 1'b1);
        check_eq("t5_ack1", {s_if.cyc, m0_if.stall, m0_if.ack, m0_if.rdata},
                 {3'b011, 32'h0});
        @(negedge clk);
        check_eq("t5_ack2", {s_if.cyc, m0_if.stall, m0_if.ack, m0_if.rdata},
                 {3'b011, 32'h0});
        @(negedge clk);
        check_eq("t5_idle", {s_if.cyc, m0_if.ack, m1_if.ack, dut.outstanding}, 6'd0);
        step();
        m_cyc = 2'b00;
        step();
        step();
        check_eq("t5_sticky", timeout, 1'b1);
`else
        repeat (40) step();
        @(negedge clk);
        check_eq("t5_no_tmo", {timeout, s_if.cyc, dut.outstanding}, {2'b01, 3'd2});
        step();
        m_cyc = 2'b00;
        step();
`endif

        // 6: reset mid-burst with 2 outstanding
        do_reset();
        model_en = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        step();
        step();
        step();
        @(negedge clk);
        check_eq("t6_pre", dut.outstanding, 3'd2);
        step();
        reset = 1'b1; sl_ack = 1'b1;
        step();
        @(negedge clk);
        check_eq("t6_reset", {s_if.cyc, s_if.stb, m0_if.stall, m1_if.stall, m0_if.ack,
                              m1_if.ack, dut.outstanding}, {6'b001100, 3'd0});
        step();
        idle_in();
        reset = 1'b0;
        step();

        // Randomized traffic against the model
        nak = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_cyc[i]) m_cyc[i] = ($urandom_range(5) == 0);
                else if ($urandom_range(9) == 0) m_cyc[i] = 1'b0;
                m_stb[i] = m_cyc[i] & 1'($urandom_range(1));
                m_we[i] = 1'($urandom_range(1));
                m_addr[i] = AW'($urandom);
                m_sel[i] = SW'($urandom);
                m_wdata[i] = $urandom;
            end
            sl_stall = ($urandom_range(3) == 0);
            sl_rdata = $urandom;
            if (outst > 0) begin
                sl_ack = (nak >= 4) || ($urandom_range(1) == 1);
                nak = sl_ack ? 0 : nak + 1;
            end else begin
                sl_ack = 1'b0;
                nak = 0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
